// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM read arbiter.
//   state_t   : arbiter FSM encoding (IDLE=0, ACCESS=1)
//   owner_t   : which requester owns the in-flight read (OWN_D=0, OWN_F=1)
//   STARVE_MAX_DEF : default number of consecutive data grants tolerated
//                    while a fetch request is waiting
package sram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_F = 1'b1
  } owner_t;

  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter.
//   clk, reset : clock and synchronous active-low reset
//   inc        : count one more data grant taken while fetch waited
//   clr        : clear (takes priority over inc)
//   count      : current value, never exceeds MAX
//   at_max     : count has reached MAX
module arb_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port read arbiter in front of a single-ported asynchronous-read SRAM.
// Execute (d) reads have fixed priority over instruction fetch (f), except
// that after STARVE_MAX consecutive d grants with f waiting, f wins once.
//
// Handshake: a request is accepted in a cycle where x_req and x_gnt are both
// high. The requester must hold x_addr stable while x_req is high and must
// drop x_req or present a new address in the cycle after x_gnt. The result
// comes back two cycles after acceptance as a one-cycle x_rvalid pulse with
// the byte on rdata; rdata holds until the next response.
//
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   f_req/f_addr/f_gnt   : fetch request, address, combinational grant
//   f_rvalid             : fetch response pulse
//   d_req/d_addr/d_gnt   : data request, address, combinational grant
//   d_rvalid             : data response pulse
//   rdata                : shared response byte
//   mem_address/mem_data : registered SRAM address, async SRAM read data
//   busy                 : FSM is in ACCESS (also serves as state debug view)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  state_t             state_q, state_d;
  owner_t             owner_q;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starve_at_max;
  logic               f_wins;
  logic               can_accept;

  // f takes the slot when it is alone, or when d has had its fill.
  assign f_wins     = f_req && (!d_req || starve_at_max);
  // Grants are suppressed while reset is asserted.
  assign can_accept = reset && (state_q == IDLE);
  assign f_gnt      = can_accept && f_wins;
  assign d_gnt      = can_accept && d_req && !f_wins;
  assign busy       = (state_q == ACCESS);

  arb_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (d_gnt && f_req),
    .clr    (f_gnt || !f_req),
    .count  (starve_cnt),
    .at_max (starve_at_max)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (f_gnt || d_gnt) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and owner only move on an accept edge, so the SRAM address is
  // never disturbed while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_address <= '0;
      owner_q     <= OWN_D;
    end else if (f_gnt) begin
      mem_address <= f_addr;
      owner_q     <= OWN_F;
    end else if (d_gnt) begin
      mem_address <= d_addr;
      owner_q     <= OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata    <= '0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else if (state_q == ACCESS) begin
      rdata    <= mem_data;
      f_rvalid <= (owner_q == OWN_F);
      d_rvalid <= (owner_q == OWN_D);
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic       clk;
  logic       reset;
  logic       f_req;
  logic [7:0] f_addr;
  logic       f_gnt;
  logic       f_rvalid;
  logic       d_req;
  logic [7:0] d_addr;
  logic       d_gnt;
  logic       d_rvalid;
  logic [7:0] rdata;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // {is_fetch, data}
  logic [8:0] exp_q[$];

  sram_arbiter #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_gnt       (f_gnt),
    .f_rvalid    (f_rvalid),
    .d_req       (d_req),
    .d_addr      (d_addr),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .busy        (busy)
  );

  // ---------------- clock / SRAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [7:0] a);
    case (a)
      8'h02:   return 8'h80;
      8'h03:   return 8'h01;
      8'h04:   return 8'h81;
      8'h08:   return 8'h3C;
      8'h0A:   return 8'h92;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  assign mem_data = mem_model(mem_address);

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive one cycle of requests, check the
  // combinational grants, queue the expected responses, wait for the next
  // falling edge (registered outputs of that cycle are then visible).
  task automatic step(input logic fr, input logic [7:0] fa,
                      input logic dr, input logic [7:0] da,
                      input logic efg, input logic edg, input string tag);
    f_req  = fr;
    f_addr = fa;
    d_req  = dr;
    d_addr = da;
    #1;
    check({tag, " f_gnt"}, {31'd0, f_gnt}, {31'd0, efg});
    check({tag, " d_gnt"}, {31'd0, d_gnt}, {31'd0, edg});
    if (efg) exp_q.push_back({1'b1, mem_model(fa)});
    if (edg) exp_q.push_back({1'b0, mem_model(da)});
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (f_rvalid || d_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rvalid f", {31'd0, f_rvalid}, {31'd0, e[8]});
        check("rvalid d", {31'd0, d_rvalid}, {31'd0, !e[8]});
        check("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset  = 1'b0;
    f_req  = 1'b1;
    f_addr = 8'h55;
    d_req  = 1'b1;
    d_addr = 8'h66;
    @(negedge clk);
    @(negedge clk);
    check("reset f_gnt", {31'd0, f_gnt}, 32'd0);
    check("reset d_gnt", {31'd0, d_gnt}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset mem_address", {24'd0, mem_address}, 32'd0);
    check("reset rdata", {24'd0, rdata}, 32'd0);
    check("reset rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
    f_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Single fetch
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, "single N");
    check("single busy N+1", {31'd0, busy}, 32'd1);
    check("single mem_address N+1", {24'd0, mem_address}, 32'h04);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "single N+1");
    check("single f_rvalid N+2", {31'd0, f_rvalid}, 32'd1);
    check("single rdata N+2", {24'd0, rdata}, 32'h81);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "single N+2");
    check("single f_rvalid cleared", {31'd0, f_rvalid}, 32'd0);

    // Simultaneous: d first, then f in the d rvalid cycle
    step(1'b1, 8'h02, 1'b1, 8'h0A, 1'b0, 1'b1, "simul d");
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, "simul access");
    check("simul d_rvalid", {31'd0, d_rvalid}, 32'd1);
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, "simul f");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "simul access2");
    check("simul f rdata", {24'd0, rdata}, 32'h80);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "simul idle");

    // Starvation: exactly 4 d grants, then f, then d wins again (count cleared)
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h10, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b1, "starve d");
      step(1'b1, 8'h10, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, "starve access");
    end
    step(1'b1, 8'h10, 1'b1, 8'h24, 1'b1, 1'b0, "starve f");
    step(1'b1, 8'h11, 1'b1, 8'h24, 1'b0, 1'b0, "starve access f");
    step(1'b1, 8'h11, 1'b1, 8'h24, 1'b0, 1'b1, "starve cleared");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "starve access d");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "starve idle");

    // Back-to-back fetches
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, "b2b 02");
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, "b2b access");
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 1'b0, "b2b 03");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, "b2b access");
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, "b2b 04");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "b2b access");
    check("b2b last rdata", {24'd0, rdata}, 32'h81);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "b2b idle");

    // Reset during ACCESS of a d read: transaction dropped
    step(1'b0, 8'h00, 1'b1, 8'h0A, 1'b0, 1'b1, "rst d");
    void'(exp_q.pop_back());
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "rst access");
    check("rst d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rst rdata", {24'd0, rdata}, 32'd0);
    check("rst mem_address", {24'd0, mem_address}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "rst idle");
    check("rst no late rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);

    // Idle hold after a read at 0x08
    step(1'b1, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, "hold read");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "hold access");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "hold idle");
      check("hold mem_address", {24'd0, mem_address}, 32'h08);
      check("hold rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
      check("hold rdata", {24'd0, rdata}, 32'h3C);
    end

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port read arbiter sitting in front of the 256×8 program/data SRAM. It shares the SRAM's single address/data path between the instruction-fetch unit and the execute unit's operand-read path. Execute reads have fixed priority, and a bounded starvation guard keeps fetch moving. Each accepted request is registered onto the SRAM address lines, and the returned byte is captured into a response register.

## Interface
Parameters:
- ADDR_W, 8, SRAM address width
- DATA_W, 8, SRAM data width
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch request waits (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset, sampled on rising clk
- f_req  in  1  fetch request; f_addr must stay stable while high
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_rvalid  out  1  one-cycle pulse; rdata holds fetch result
- d_req  in  1  data-read request; d_addr must stay stable while high
- d_addr  in  ADDR_W  data address
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle pulse; rdata holds data result
- rdata  out  DATA_W  shared response byte, held until the next response
- mem_address  out  ADDR_W  registered SRAM address
- mem_data  in  DATA_W  SRAM asynchronous read data
- busy  out  1  high while in ACCESS

## Operation
- FSM states:
  - IDLE: may accept a request.
  - ACCESS: the SRAM read is in flight; no acceptance.
- IDLE → ACCESS on any accepted request. ACCESS → IDLE unconditionally after 1 cycle.
- Winner in IDLE:
  - Only one request high: that request wins.
  - Both high: d wins, unless starve_cnt == STARVE_MAX, in which case f wins.
- Gating: x_gnt = (state==IDLE) && winner==x && x_req. Both gnts are never high together.
- On the accept edge:
  - mem_address ← winning address
  - owner ← winner
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments, saturating, on a d grant while f_req is high.
  - Clears on an f grant, or on any edge with f_req low.
- ACCESS edge:
  - rdata ← mem_data
  - x_rvalid ← 1 for the owner only
- rvalid is cleared on the following edge.
- mem_address holds its last value when idle. No spurious SRAM address changes are allowed.
- Requester rule: a requester drops req, or presents a new address, in the cycle after seeing gnt. A req still high in the next IDLE cycle is a new request.

## Timing
- Cycle N: req and gnt high. Cycle N+1: busy=1, mem_address valid. Cycle N+2: x_rvalid=1, rdata valid, and a new request may be accepted in the same cycle.
- Latency: 2 cycles from accept to rvalid. Peak throughput: 1 access per 2 cycles.
- Reset (reset==0 at an edge) sets:
  - state=IDLE, mem_address=0, rdata=0
  - f_rvalid=d_rvalid=0, owner=d, starve_cnt=0
  - busy=0
- Outputs gnt=0 during reset.
- Reset asserted during ACCESS: the transaction is dropped, no rvalid is produced, and rdata becomes 0.
- Requests arriving during ACCESS wait. They are not lost while held high.
- Saturation: starve_cnt never exceeds STARVE_MAX, so no wrap-around.

## Structure
- Shared package sram_arb_pkg holds:
  - state encoding (IDLE=0, ACCESS=1)
  - owner encoding (OWN_D=0, OWN_F=1)
  - default STARVE_MAX
- One sub-module, arb_starve_ctr: saturating counter with inc/clr inputs and an at_max output.
- Top level contains the FSM, the winner logic, and the address/response registers.

## Test plan
- Single fetch: f_req=1, f_addr=0x04, mem_data model returns 0x81 → f_gnt at N, mem_address=0x04 at N+1, f_rvalid=1 and rdata=0x81 at N+2, d_rvalid=0 throughout.
- Simultaneous requests: f_req=d_req=1, f_addr=0x02, d_addr=0x0A → d granted first (rdata=0x92), then f granted in the rvalid cycle (rdata=0x80 two cycles later).
- Starvation: d_req held high with changing addresses and f_req held high, STARVE_MAX=4 → exactly 4 d grants, then an f grant, then starve_cnt=0.
- Back-to-back: f_req re-presented every cycle at 0x02,0x03,0x04 → one grant per 2 cycles, rdata sequence 0x80,0x01,0x81, never two gnts in ACCESS.
- Reset mid-access: reset=0 in the ACCESS cycle of a d read → no d_rvalid; rdata=0, mem_address=0, busy=0 next cycle.
- Idle hold: no requests for 10 cycles after a read at 0x08 → mem_address stays 0x08, no rvalid pulses.
